// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, the NOP word and
// a small alignment helper.
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_BOOT  = 2'd0,
      FETCH_RUN   = 2'd1,
      FETCH_FAULT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

   // A fetch address is usable only when it points at a whole word.
   function automatic logic word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. A bubble clears it to a NOP with valid low and
// takes priority over a load; with neither asserted the contents are held.
import instruction_fetch_pkg::*;

module if_id_register (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_i,
   input  logic        bubble_i,
   input  logic [31:0] instruction_i,
   input  logic [31:0] pc_plus4_i,
   output logic        valid_o,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_plus4_o
);

   logic        valid_q;
   logic [31:0] instruction_q;
   logic [31:0] pc_plus4_q;

   // Bubble beats load; otherwise hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q       <= 1'b0;
         instruction_q <= NOP_INSTRUCTION;
         pc_plus4_q    <= 32'h0;
      end else if (bubble_i) begin
         valid_q       <= 1'b0;
         instruction_q <= NOP_INSTRUCTION;
         pc_plus4_q    <= 32'h0;
      end else if (load_i) begin
         valid_q       <= 1'b1;
         instruction_q <= instruction_i;
         pc_plus4_q    <= pc_plus4_i;
      end
   end

   assign valid_o       = valid_q;
   assign instruction_o = instruction_q;
   assign pc_plus4_o    = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses instruction memory, captures the
// returned word into IF/ID, and latches a sticky fault on a misaligned
// redirect or a PC that walks off the end of memory.
import instruction_fetch_pkg::*;

module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] IMEM_SIZE = 32'h0000_0400
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_instruction,
   output logic        if_id_valid,
   output logic [31:0] if_id_instruction,
   output logic [31:0] if_id_pc_plus4,
   output logic        fault,
   output logic [31:0] fault_pc
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         fault_q, fault_d;
   logic [31:0]  fault_pc_q, fault_pc_d;
   logic         load;
   logic         bubble;
   logic [31:0]  pc_plus4;

   // Wraps modulo 2^32 by construction.
   assign pc_plus4 = pc_q + 32'd4;

   // Next-state and IF/ID control, RUN priority: bad redirect, redirect,
   // stall, out-of-range PC, sequential fetch.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      load       = 1'b0;
      bubble     = 1'b0;
      case (state_q)
         FETCH_BOOT: begin
            state_d = FETCH_RUN;
         end
         FETCH_RUN: begin
            if (redirect_valid && !word_aligned(redirect_pc)) begin
               state_d    = FETCH_FAULT;
               fault_d    = 1'b1;
               fault_pc_d = redirect_pc;
               bubble     = 1'b1;
            end else if (redirect_valid) begin
               pc_d   = redirect_pc;
               bubble = 1'b1;
            end else if (stall) begin
               // Hold PC and IF/ID; whatever memory returns is dropped.
            end else if (pc_q >= IMEM_SIZE) begin
               state_d    = FETCH_FAULT;
               fault_d    = 1'b1;
               fault_pc_d = pc_q;
               bubble     = 1'b1;
            end else begin
               load = 1'b1;
               pc_d = pc_plus4;
            end
         end
         FETCH_FAULT: begin
            bubble = 1'b1;
         end
         default: begin
            // Unreachable encoding: park safely in the fault state.
            state_d    = FETCH_FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            bubble     = 1'b1;
         end
      endcase
   end

   // FSM, PC and registered fault outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= FETCH_BOOT;
         pc_q       <= RESET_PC;
         fault_q    <= 1'b0;
         fault_pc_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   if_id_register u_if_id (
      .clock         (clock),
      .reset         (reset),
      .load_i        (load),
      .bubble_i      (bubble),
      .instruction_i (imem_instruction),
      .pc_plus4_i    (pc_plus4),
      .valid_o       (if_id_valid),
      .instruction_o (if_id_instruction),
      .pc_plus4_o    (if_id_pc_plus4)
   );

   assign imem_address = pc_q;
   assign fault        = fault_q;
   assign fault_pc     = fault_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a bench-side memory, a cycle model
// built from the fetch rules, a per-cycle compare and literal spot checks.
module tb_instruction_fetch;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] IMEM_SIZE = 32'h0000_0400;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_address;
   logic [31:0] imem_instruction;
   logic        if_id_valid;
   logic [31:0] if_id_instruction;
   logic [31:0] if_id_pc_plus4;
   logic        fault;
   logic [31:0] fault_pc;

   int errors = 0;
   int checks = 0;
   logic cmp_en = 1'b0;

   logic [31:0] mem [256];

   instruction_fetch #(.RESET_PC(RESET_PC), .IMEM_SIZE(IMEM_SIZE)) dut (
      .clock             (clock),
      .reset             (reset),
      .stall             (stall),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .imem_address      (imem_address),
      .imem_instruction  (imem_instruction),
      .if_id_valid       (if_id_valid),
      .if_id_instruction (if_id_instruction),
      .if_id_pc_plus4    (if_id_pc_plus4),
      .fault             (fault),
      .fault_pc          (fault_pc)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'h400) return mem[a[9:2]];
      return 32'hDEAD_BEEF;
   endfunction

   assign imem_instruction = mem_word(imem_address);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what the stage must hold after each edge.
   logic        m_boot, m_fault;
   logic [31:0] m_pc, m_fault_pc, m_ins, m_pp4;
   logic        m_v;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_boot = 1'b1; m_fault = 1'b0; m_pc = RESET_PC; m_fault_pc = 32'h0;
         m_v = 1'b0; m_ins = 32'h0; m_pp4 = 32'h0;
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_fault) begin
         m_v = 1'b0; m_ins = 32'h0; m_pp4 = 32'h0;
      end else if (redirect_valid) begin
         m_v = 1'b0; m_ins = 32'h0; m_pp4 = 32'h0;
         if (redirect_pc % 4 != 0) begin
            m_fault = 1'b1; m_fault_pc = redirect_pc;
         end else begin
            m_pc = redirect_pc;
         end
      end else if (!stall) begin
         if (m_pc >= IMEM_SIZE) begin
            m_fault = 1'b1; m_fault_pc = m_pc;
            m_v = 1'b0; m_ins = 32'h0; m_pp4 = 32'h0;
         end else begin
            m_v = 1'b1; m_ins = mem_word(m_pc); m_pp4 = m_pc + 4;
            m_pc = m_pc + 4;
         end
      end
   end

   // Per-cycle compare, away from the rising edge.
   always @(negedge clock) begin
      if (cmp_en) begin
         chk("model_addr",     imem_address,             m_pc);
         chk("model_valid",    {31'b0, if_id_valid},     {31'b0, m_v});
         chk("model_instr",    if_id_instruction,        m_ins);
         chk("model_pc_plus4", if_id_pc_plus4,           m_pp4);
         chk("model_fault",    {31'b0, fault},           {31'b0, m_fault});
         chk("model_fault_pc", fault_pc,                 m_fault_pc);
      end
   end

   task automatic step();
      @(negedge clock);
   endtask

   task automatic expect_ifid(input string tag, input logic v, input logic [31:0] ins,
                              input logic [31:0] pp4, input logic [31:0] addr);
      chk({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
      chk({tag, "_instr"}, if_id_instruction, ins);
      chk({tag, "_pp4"},   if_id_pc_plus4, pp4);
      chk({tag, "_addr"},  imem_address, addr);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
      mem[16] = 32'h0000_4040; mem[255] = 32'h0000_03FC;

      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      step(); step();
      expect_ifid("reset", 1'b0, 32'h0, 32'h0, 32'h0);
      chk("reset_fault", {31'b0, fault}, 32'h0);
      chk("reset_fault_pc", fault_pc, 32'h0);
      reset = 1'b0; cmp_en = 1'b1;

      // Free run: boot cycle then sequential captures.
      step(); expect_ifid("boot", 1'b0, 32'h0, 32'h0, 32'h0);
      step(); expect_ifid("run0", 1'b1, 32'h11, 32'h4, 32'h4);
      step(); expect_ifid("run1", 1'b1, 32'h22, 32'h8, 32'h8);
      // Stall two cycles at pc=8.
      stall = 1'b1;
      step(); expect_ifid("stall0", 1'b1, 32'h22, 32'h8, 32'h8);
      step(); expect_ifid("stall1", 1'b1, 32'h22, 32'h8, 32'h8);
      stall = 1'b0;
      step(); expect_ifid("resume", 1'b1, 32'h33, 32'hC, 32'hC);

      // Redirect while stalled: redirect wins.
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
      step(); expect_ifid("redir", 1'b0, 32'h0, 32'h0, 32'h40);
      stall = 1'b0; redirect_valid = 1'b0;
      step(); expect_ifid("redir_fetch", 1'b1, 32'h4040, 32'h44, 32'h44);

      // Last legal word, then out-of-range fault.
      redirect_valid = 1'b1; redirect_pc = 32'h3FC;
      step(); expect_ifid("last_redir", 1'b0, 32'h0, 32'h0, 32'h3FC);
      redirect_valid = 1'b0;
      step(); expect_ifid("last_word", 1'b1, 32'h3FC, 32'h400, 32'h400);
      chk("last_word_fault", {31'b0, fault}, 32'h0);
      step(); expect_ifid("range_fault", 1'b0, 32'h0, 32'h0, 32'h400);
      chk("range_fault_flag", {31'b0, fault}, 32'h1);
      chk("range_fault_pc", fault_pc, 32'h400);

      // Asynchronous reset between edges while faulted.
      #2 reset = 1'b1;
      #1;
      chk("async_rst_fault", {31'b0, fault}, 32'h0);
      chk("async_rst_addr", imem_address, RESET_PC);
      chk("async_rst_valid", {31'b0, if_id_valid}, 32'h0);
      chk("async_rst_fault_pc", fault_pc, 32'h0);
      step(); reset = 1'b0;

      // Misaligned redirect: sticky fault, later redirects ignored.
      step(); step(); expect_ifid("pre_mis", 1'b1, 32'h11, 32'h4, 32'h4);
      redirect_valid = 1'b1; redirect_pc = 32'h42;
      step(); expect_ifid("mis", 1'b0, 32'h0, 32'h0, 32'h4);
      chk("mis_fault", {31'b0, fault}, 32'h1);
      chk("mis_fault_pc", fault_pc, 32'h42);
      redirect_pc = 32'h40;
      step(); stall = 1'b1;
      step(); redirect_valid = 1'b0; stall = 1'b0;
      step(); expect_ifid("sticky", 1'b0, 32'h0, 32'h0, 32'h4);
      chk("sticky_fault_pc", fault_pc, 32'h42);

      // Reset asserted mid-stall.
      #2 reset = 1'b1;
      #1;
      chk("rst2_fault", {31'b0, fault}, 32'h0);
      step(); reset = 1'b0;
      step(); step(); stall = 1'b1;
      step(); expect_ifid("stall_hold", 1'b1, 32'h11, 32'h4, 32'h4);
      #2 reset = 1'b1;
      #1;
      expect_ifid("rst_mid_stall", 1'b0, 32'h0, 32'h0, RESET_PC);
      step(); reset = 1'b0; stall = 1'b0;
      step(); step();

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
